uart_rx_cmd_ctrl: RTL

Command sequencer behind the UART receiver. Consumes the receiver's byte stream (`data_valid`/`p_data`), decodes multi-byte command frames, and drives the register-file write/read strobes and the ALU enable. Results go back out through the UART transmitter with a busy-based handshake. It is the only master of the register file and ALU in the system.

---
 rtl/uart_rx_cmd_ctrl_if.sv | 47 ++++
 rtl/uart_rx_cmd_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_ctrl_if.sv
// uart_rx_cmd_ctrl_if
//   Bundles every signal between the UART command sequencer and its
//   neighbours: the UART receiver byte stream, the register file, the ALU,
//   and the UART transmitter.
//   master : the command sequencer (drives rf_*, alu_en/alu_fun, tx_*, busy)
//   slave  : the surrounding peripherals (drive rx_*, rf_rd_*, alu_out*, tx_busy)
interface uart_rx_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
) ();
  // UART receiver
  logic                  rx_data_valid;
  logic [DATA_W-1:0]     rx_p_data;
  // register file
  logic [DATA_W-1:0]     rf_rd_data;
  logic                  rf_rd_valid;
  logic [ADDR_W-1:0]     rf_addr;
  logic                  rf_wr_en;
  logic [DATA_W-1:0]     rf_wr_data;
  logic                  rf_rd_en;
  // ALU
  logic [2*DATA_W-1:0]   alu_out;
  logic                  alu_out_valid;
  logic                  alu_en;
  logic [FUN_W-1:0]      alu_fun;
  // UART transmitter
  logic                  tx_busy;
  logic [DATA_W-1:0]     tx_p_data;
  logic                  tx_data_valid;
  // status
  logic                  busy;

  modport master (
    input  rx_data_valid, rx_p_data, rf_rd_data, rf_rd_valid,
           alu_out, alu_out_valid, tx_busy,
    output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en,
           alu_en, alu_fun, tx_p_data, tx_data_valid, busy
  );

  modport slave (
    output rx_data_valid, rx_p_data, rf_rd_data, rf_rd_valid,
           alu_out, alu_out_valid, tx_busy,
    input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en,
           alu_en, alu_fun, tx_p_data, tx_data_valid, busy
  );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl
//   Command sequencer behind the UART receiver. Decodes command frames
//   (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU on existing
//   operands), drives register-file and ALU strobes, and returns results
//   through the UART transmitter using its busy handshake.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : uart_rx_cmd_ctrl_if master modport (rx byte stream in, rf/alu
//          strobes out, tx byte out, busy out)
//   All outputs are registered.
module uart_rx_cmd_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
) (
  input logic               clk,
  input logic               rst,
  uart_rx_cmd_ctrl_if.master bus
);

  localparam logic [DATA_W-1:0] OPC_WR  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] OPC_RD  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] OPC_ALU = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] OPC_NOP = DATA_W'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FUN, ALU_WAIT, TX_LO, TX_GAP, TX_HI
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic                rf_wr_en_q, rf_wr_en_d;
  logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                rf_rd_en_q, rf_rd_en_d;
  logic                alu_en_q, alu_en_d;
  logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;
  logic [DATA_W-1:0]   tx_p_data_q, tx_p_data_d;
  logic                tx_dv_q, tx_dv_d;
  logic                busy_q, busy_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                two_q, two_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rf_addr_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_data_q <= '0;
      rf_rd_en_q   <= 1'b0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      tx_p_data_q  <= '0;
      tx_dv_q      <= 1'b0;
      busy_q       <= 1'b0;
      res_q        <= '0;
      two_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
      tx_p_data_q  <= tx_p_data_d;
      tx_dv_q      <= tx_dv_d;
      busy_q       <= busy_d;
      res_q        <= res_d;
      two_q        <= two_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_data_d = rf_wr_data_q;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    alu_fun_d    = alu_fun_q;
    tx_p_data_d  = tx_p_data_q;
    tx_dv_d      = 1'b0;
    res_d        = res_q;
    two_d        = two_q;

    case (state_q)
      IDLE: begin
        if (bus.rx_data_valid) begin
          if (bus.rx_p_data == OPC_WR)       state_d = WR_ADDR;
          else if (bus.rx_p_data == OPC_RD)  state_d = RD_ADDR;
          else if (bus.rx_p_data == OPC_ALU) state_d = OP_A;
          else if (bus.rx_p_data == OPC_NOP) state_d = ALU_FUN;
        end
      end
      WR_ADDR: begin
        if (bus.rx_data_valid) begin
          rf_addr_d = bus.rx_p_data[ADDR_W-1:0];
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.rx_data_valid) begin
          rf_wr_data_d = bus.rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.rx_data_valid) begin
          rf_addr_d  = bus.rx_p_data[ADDR_W-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.rf_rd_valid) begin
          res_d   = {{DATA_W{1'b0}}, bus.rf_rd_data};
          two_d   = 1'b0;
          state_d = TX_LO;
        end
      end
      OP_A: begin
        if (bus.rx_data_valid) begin
          rf_addr_d    = '0;
          rf_wr_data_d = bus.rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = OP_B;
        end
      end
      OP_B: begin
        if (bus.rx_data_valid) begin
          rf_addr_d    = ADDR_W'(1);
          rf_wr_data_d = bus.rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = ALU_FUN;
        end
      end
      ALU_FUN: begin
        if (bus.rx_data_valid) begin
          alu_fun_d = bus.rx_p_data[FUN_W-1:0];
          alu_en_d  = 1'b1;
          state_d   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (bus.alu_out_valid) begin
          res_d   = bus.alu_out;
          two_d   = 1'b1;
          state_d = TX_LO;
        end
      end
      TX_LO: begin
        if (!bus.tx_busy) begin
          tx_p_data_d = res_q[DATA_W-1:0];
          tx_dv_d     = 1'b1;
          state_d     = two_q ? TX_GAP : IDLE;
        end
      end
      TX_GAP: begin
        // transmitter must acknowledge the low byte before the high byte goes out
        if (bus.tx_busy) state_d = TX_HI;
      end
      TX_HI: begin
        if (!bus.tx_busy) begin
          tx_p_data_d = res_q[2*DATA_W-1:DATA_W];
          tx_dv_d     = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // busy covers the final strobe cycle so it drops one cycle after it
    busy_d = (state_d != IDLE) | rf_wr_en_d | tx_dv_d;
  end

  assign bus.rf_addr       = rf_addr_q;
  assign bus.rf_wr_en      = rf_wr_en_q;
  assign bus.rf_wr_data    = rf_wr_data_q;
  assign bus.rf_rd_en      = rf_rd_en_q;
  assign bus.alu_en        = alu_en_q;
  assign bus.alu_fun       = alu_fun_q;
  assign bus.tx_p_data     = tx_p_data_q;
  assign bus.tx_data_valid = tx_dv_q;
  assign bus.busy          = busy_q;

endmodule
